// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and round-constant table used by the key schedule.
package aes_pkg;

   localparam int NR     = 10;
   localparam int KEY_W  = 128;
   localparam int WORD_W = 32;

   typedef logic [3:0] round_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      LAST   = 2'd2
   } state_e;

   // Indexed by the round being produced (1..10); other indices are unused.
   function automatic logic [7:0] rcon(input round_t r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, substituted byte out. Shared with the cipher SubBytes stage.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Entry 0 sits in the most significant byte, so byte a lives at bit offset 8*(255-a).
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, streamed out and kept in an 11-entry bank.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               key_valid,
   output logic               key_ready,
   output logic               rk_valid,
   output logic [3:0]         rk_round,
   output logic [KEY_W-1:0]   rk_data,
   output logic               done,
   output logic               keys_valid,
   input  logic [3:0]         rd_addr,
   output logic [KEY_W-1:0]   rd_data
);

   state_e             state_q;
   logic [KEY_W-1:0]   rk_data_q;
   round_t             rk_round_q;
   logic               rk_valid_q;
   logic               done_q;
   logic               keys_valid_q;
   logic [KEY_W-1:0]   bank_q [0:NR];

   logic [WORD_W-1:0]  w0, w1, w2, w3;
   logic [WORD_W-1:0]  rot_w, sub_w, t_w;
   logic [WORD_W-1:0]  w0_d, w1_d, w2_d, w3_d;
   logic [KEY_W-1:0]   key_d;
   round_t             round_d;

   assign w0 = rk_data_q[127:96];
   assign w1 = rk_data_q[95:64];
   assign w2 = rk_data_q[63:32];
   assign w3 = rk_data_q[31:0];

   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot_w[8*i +: 8]),
         .out_o (sub_w[8*i +: 8])
      );
   end

   assign round_d = rk_round_q + 4'd1;
   assign t_w     = sub_w ^ {rcon(round_d), 24'h000000};
   assign w0_d    = w0 ^ t_w;
   assign w1_d    = w1 ^ w0_d;
   assign w2_d    = w2 ^ w1_d;
   assign w3_d    = w3 ^ w2_d;
   assign key_d   = {w0_d, w1_d, w2_d, w3_d};

   // Handshake: key_in is taken on any edge where key_valid and key_ready are both high;
   // key_valid while busy is dropped, not queued.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= IDLE;
         rk_data_q    <= '0;
         rk_round_q   <= '0;
         rk_valid_q   <= 1'b0;
         done_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         for (int i = 0; i <= NR; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  rk_data_q    <= key_in;
                  rk_round_q   <= '0;
                  rk_valid_q   <= 1'b1;
                  keys_valid_q <= 1'b0;
                  bank_q[0]    <= key_in;
                  state_q      <= EXPAND;
               end
            end
            EXPAND: begin
               rk_data_q       <= key_d;
               rk_round_q      <= round_d;
               bank_q[round_d] <= key_d;
               if (rk_round_q == round_t'(NR - 1)) begin
                  done_q       <= 1'b1;
                  keys_valid_q <= 1'b1;
                  state_q      <= LAST;
               end
            end
            LAST: begin
               rk_valid_q <= 1'b0;
               done_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign key_ready  = (state_q == IDLE);
   assign rk_valid   = rk_valid_q;
   assign rk_round   = rk_round_q;
   assign rk_data    = rk_data_q;
   assign done       = done_q;
   assign keys_valid = keys_valid_q;
   assign rd_data    = (rd_addr > round_t'(NR)) ? '0 : bank_q[rd_addr];

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: hand-computed FIPS-197 vectors, protocol corners, and random keys
// against a key-schedule model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         nrst;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         rk_valid;
   logic [3:0]   rk_round;
   logic [127:0] rk_data;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rd_addr;
   logic [127:0] rd_data;

   always #50 clk = ~clk;

   aes_key_expand #(.NR(10)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .key_in     (key_in),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .rk_valid   (rk_valid),
      .rk_round   (rk_round),
      .rk_data    (rk_data),
      .done       (done),
      .keys_valid (keys_valid),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   int           n_pass  = 0;
   int           n_total = 0;
   logic [7:0]   sbox_ref [0:255];
   logic [127:0] exp_ks [0:10];
   logic [127:0] got_ks [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   typedef struct {
      logic [127:0] key;
      int           rnd;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [6];

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic build_model(input logic [127:0] k);
      logic [31:0] a, b, c, d, rot, sub;
      logic [7:0]  rc;
      exp_ks[0] = k;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         {a, b, c, d} = exp_ks[r-1];
         rot = {d[23:0], d[31:24]};
         for (int j = 0; j < 4; j++) sub[8*j +: 8] = sbox_ref[rot[8*j +: 8]];
         a = a ^ sub ^ {rc, 24'h000000};
         b = b ^ a;
         c = c ^ b;
         d = d ^ c;
         exp_ks[r] = {a, b, c, d};
         rc = xtime(rc);
      end
   endtask

   // ---------------- checking / driving ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called right after the accepting edge; walks rounds 0..10 and the return to idle.
   task automatic follow_stream(input string tag, input logic [127:0] swap_key);
      for (int r = 0; r <= 10; r++) begin
         if (r > 0) tick();
         if (r == 5) key_in = swap_key;
         got_ks[r] = rk_data;
         chk($sformatf("%s rk_data r%0d", tag, r), rk_data, exp_ks[r]);
         chk($sformatf("%s rk_round r%0d", tag, r), 128'(rk_round), 128'(r));
         chk($sformatf("%s rk_valid r%0d", tag, r), 128'(rk_valid), 128'(1));
         chk($sformatf("%s done r%0d", tag, r), 128'(done), 128'(r == 10));
         chk($sformatf("%s keys_valid r%0d", tag, r), 128'(keys_valid), 128'(r == 10));
         chk($sformatf("%s key_ready r%0d", tag, r), 128'(key_ready), 128'(0));
      end
      tick();
      chk({tag, " idle key_ready"}, 128'(key_ready), 128'(1));
      chk({tag, " idle rk_valid"}, 128'(rk_valid), 128'(0));
      chk({tag, " idle done"}, 128'(done), 128'(0));
      chk({tag, " idle keys_valid"}, 128'(keys_valid), 128'(1));
      chk({tag, " idle rk_round"}, 128'(rk_round), 128'(10));
      chk({tag, " idle rk_data"}, rk_data, exp_ks[10]);
   endtask

   task automatic expand_key(input string tag, input logic [127:0] k);
      build_model(k);
      key_in    = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      follow_stream(tag, k);
   endtask

   task automatic check_bank(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         if (a <= 10) chk($sformatf("%s bank[%0d]", tag, a), rd_data, got_ks[a]);
         else         chk($sformatf("%s bank[%0d]", tag, a), rd_data, 128'h0);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] key_a, key_b, rk;

      vecs[0] = '{FIPS_KEY, 1, 128'ha0fafe1788542cb123a339392a6c7605};
      vecs[1] = '{FIPS_KEY, 2, 128'hf2c295f27a96b9435935807a7359f67f};
      vecs[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[3] = '{128'h0, 0, 128'h0};
      vecs[4] = '{128'h0, 1, 128'h62636363626363636263636362636363};
      vecs[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      nrst      = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      rd_addr   = '0;
      build_sbox();
      repeat (2) tick();
      nrst = 1'b1;
      chk("reset key_ready", 128'(key_ready), 128'(1));
      chk("reset rk_valid", 128'(rk_valid), 128'(0));
      chk("reset rk_round", 128'(rk_round), 128'(0));
      chk("reset rk_data", rk_data, 128'h0);
      chk("reset done", 128'(done), 128'(0));
      chk("reset keys_valid", 128'(keys_valid), 128'(0));

      // Hand-computed vectors; got_ks must also agree with the model inside follow_stream.
      for (int i = 0; i < 6; i++) begin
         expand_key($sformatf("vec%0d", i), vecs[i].key);
         chk($sformatf("vec%0d round %0d", i, vecs[i].rnd), got_ks[vecs[i].rnd], vecs[i].exp);
         check_bank($sformatf("vec%0d", i));
      end

      // key_valid held high, key changes mid-expansion: second key waits for idle.
      key_a = 128'h000102030405060708090a0b0c0d0e0f;
      key_b = 128'hffeeddccbbaa99887766554433221100;
      build_model(key_a);
      key_in    = key_a;
      key_valid = 1'b1;
      tick();
      follow_stream("heldA", key_b);
      chk("heldA round10", got_ks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check_bank("heldA");
      tick();
      key_valid = 1'b0;
      build_model(key_b);
      follow_stream("heldB", key_b);
      check_bank("heldB");

      // Reset after round 4 must abort and wipe the bank.
      build_model(FIPS_KEY);
      key_in    = FIPS_KEY;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      repeat (4) tick();
      chk("abort rk_round before reset", 128'(rk_round), 128'(4));
      chk("abort rk_data before reset", rk_data, exp_ks[4]);
      nrst = 1'b0;
      repeat (2) tick();
      nrst = 1'b1;
      chk("abort rk_valid", 128'(rk_valid), 128'(0));
      chk("abort done", 128'(done), 128'(0));
      chk("abort keys_valid", 128'(keys_valid), 128'(0));
      chk("abort key_ready", 128'(key_ready), 128'(1));
      chk("abort rk_data", rk_data, 128'h0);
      for (int a = 0; a <= 10; a++) begin
         rd_addr = 4'(a);
         #1;
         chk($sformatf("abort bank[%0d]", a), rd_data, 128'h0);
      end
      tick();
      chk("abort stays idle", 128'(rk_valid), 128'(0));

      // Random keys against the model.
      for (int n = 0; n < 50; n++) begin
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand_key($sformatf("rnd%0d", n), rk);
         for (int a = 0; a <= 10; a++) got_ks[a] = exp_ks[a];
         check_bank($sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
